// File: rtl/prod_accum_16bit.sv
// Frame accumulator for the pipelined multiplier: sums each group of LEN valid
// products and presents the sum through a one-entry valid/ready output register.
module prod_accum_16bit #(
    parameter int PROD_W = 16,
    parameter int LEN    = 4,
    parameter int ACC_W  = PROD_W + $clog2(LEN),
    parameter int CNT_W  = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_en_in,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              flush,
    input  logic              acc_ready,
    output logic              acc_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LEN - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             over_q, over_d;

    logic             accept;
    logic             frame_done;
    logic [ACC_W-1:0] frame_sum;

    assign accept     = prod_en_in && !flush;
    assign frame_done = accept && (cnt_q == LAST_BEAT);
    assign frame_sum  = acc_q + ACC_W'(prod_in);

    always_comb begin
        // NOTE: every next-state signal takes its current value first, so no path leaves it unassigned and no latch is inferred.
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        over_d  = over_q;

        if (flush) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (frame_done) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = frame_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A completed frame may reuse the slot being drained on this same edge.
        if (frame_done) begin
            if (!valid_q || acc_ready) begin
                out_d   = frame_sum;
                valid_d = 1'b1;
            end else begin
                over_d = 1'b1;
            end
        end else if (valid_q && acc_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register updates from pre-edge values together.
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            over_q  <= over_d;
        end
    end

    assign acc_valid = valid_q;
    assign acc_out   = out_q;
    assign beat_cnt  = cnt_q;
    assign overrun   = over_q;

endmodule

// File: tb/tb_prod_accum_16bit.sv
// Self-checking bench for prod_accum_16bit: directed scenarios with fixed
// expected sums plus a randomized run against a frame-level reference model.
module tb_prod_accum_16bit;

    localparam int PROD_W = 16;
    localparam int LEN    = 4;
    localparam int ACC_W  = 18;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              prod_en_in;
    logic [PROD_W-1:0] prod_in;
    logic              flush;
    logic              acc_ready;
    logic              acc_valid;
    logic [ACC_W-1:0]  acc_out;
    logic [CNT_W-1:0]  beat_cnt;
    logic              overrun;

    int total = 0;
    int bad   = 0;

    // Reference model: products of the open frame, plus the output slot.
    int               frame_q[$];
    logic             m_valid;
    logic [ACC_W-1:0] m_out;
    logic             m_over;

    prod_accum_16bit #(
        .PROD_W(PROD_W), .LEN(LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prod_en_in(prod_en_in),
        .prod_in   (prod_in),
        .flush     (flush),
        .acc_ready (acc_ready),
        .acc_valid (acc_valid),
        .acc_out   (acc_out),
        .beat_cnt  (beat_cnt),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic void model_edge();
        int  sum;
        bit  done;
        done = 1'b0;
        if (rst) begin
            frame_q.delete();
            m_valid = 1'b0;
            m_out   = '0;
            m_over  = 1'b0;
        end else begin
            if (flush) begin
                frame_q.delete();
            end else if (prod_en_in) begin
                frame_q.push_back(int'(prod_in));
                if (frame_q.size() == LEN) begin
                    sum = 0;
                    foreach (frame_q[k]) sum += frame_q[k];
                    frame_q.delete();
                    done = 1'b1;
                    if (!m_valid || acc_ready) begin
                        m_out   = ACC_W'(sum);
                        m_valid = 1'b1;
                    end else begin
                        m_over = 1'b1;
                    end
                end
            end
            if (!done && m_valid && acc_ready) m_valid = 1'b0;
        end
    endfunction

    task automatic drive(input logic r, input logic en, input int p,
                         input logic f, input logic rdy);
        rst        = r;
        prod_en_in = en;
        prod_in    = PROD_W'(p);
        flush      = f;
        acc_ready  = rdy;
    endtask

    // Advance one rising edge, update the model, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input int p, input logic rdy);
        drive(1'b0, 1'b1, p, 1'b0, rdy);
        step();
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, $urandom, 1'b0, rdy);
        step();
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step();
        idle(1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            step();
        end
        total++;
        if (acc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", acc_valid); end
        total++;
        if (acc_out !== 18'd0) begin bad++; $display("FAIL reset_out got=%0d want=0", acc_out); end
        total++;
        if (beat_cnt !== 2'd0) begin bad++; $display("FAIL reset_beat got=%0d want=0", beat_cnt); end
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
    endtask

    task automatic test_basic_frame(input bit gaps);
        int vals[4] = '{100, 200, 300, 400};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (acc_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid gaps=%0d beat=%0d got=%0b want=0", gaps, i, acc_valid); end
            if (gaps) begin idle(1'b1); idle(1'b1); end
            send(vals[i], 1'b1);
        end
        total++;
        if (acc_valid !== 1'b1 || acc_out !== 18'd1000) begin
            bad++; $display("FAIL basic_sum gaps=%0d got valid=%0b out=%0d want valid=1 out=1000", gaps, acc_valid, acc_out);
        end
        idle(1'b1);
        total++;
        if (acc_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle gaps=%0d got valid=%0b want=0", gaps, acc_valid); end
    endtask

    task automatic test_max_values();
        do_reset();
        for (int i = 0; i < 4; i++) send(65025, 1'b1);
        total++;
        if (acc_valid !== 1'b1 || acc_out !== 18'd260100) begin
            bad++; $display("FAIL max_sum got valid=%0b out=%0d want valid=1 out=260100", acc_valid, acc_out);
        end
    endtask

    task automatic test_backpressure();
        int xfers;
        do_reset();
        for (int i = 1; i <= 4; i++) send(i, 1'b0);
        total++;
        if (acc_valid !== 1'b1 || acc_out !== 18'd10) begin
            bad++; $display("FAIL bp_hold got valid=%0b out=%0d want valid=1 out=10", acc_valid, acc_out);
        end
        for (int i = 0; i < 4; i++) send(5, 1'b0);
        total++;
        if (overrun !== 1'b1 || acc_out !== 18'd10 || acc_valid !== 1'b1) begin
            bad++; $display("FAIL bp_overrun got ovr=%0b out=%0d valid=%0b want ovr=1 out=10 valid=1", overrun, acc_out, acc_valid);
        end
        xfers = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
            if (acc_valid === 1'b1) begin
                xfers++;
                total++;
                if (acc_out !== 18'd10) begin bad++; $display("FAIL bp_xfer_data got=%0d want=10", acc_out); end
            end
            step();
        end
        total++;
        if (xfers != 1) begin bad++; $display("FAIL bp_xfer_count got=%0d want=1", xfers); end
        total++;
        if (acc_valid !== 1'b0 || overrun !== 1'b1) begin
            bad++; $display("FAIL bp_after got valid=%0b ovr=%0b want valid=0 ovr=1", acc_valid, overrun);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) send(1, 1'b0);
        for (int i = 0; i < 3; i++) send(10, 1'b0);
        total++;
        if (acc_valid !== 1'b1 || acc_out !== 18'd4) begin
            bad++; $display("FAIL b2b_pending got valid=%0b out=%0d want valid=1 out=4", acc_valid, acc_out);
        end
        send(10, 1'b1);
        total++;
        if (acc_valid !== 1'b1 || acc_out !== 18'd40 || overrun !== 1'b0) begin
            bad++; $display("FAIL b2b_replace got valid=%0b out=%0d ovr=%0b want valid=1 out=40 ovr=0", acc_valid, acc_out, overrun);
        end
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        send(5, 1'b1);
        send(6, 1'b1);
        drive(1'b0, 1'b1, 7, 1'b1, 1'b1);
        step();
        total++;
        if (beat_cnt !== 2'd0) begin bad++; $display("FAIL flush_beat got=%0d want=0", beat_cnt); end
        for (int i = 0; i < 4; i++) send(1, 1'b1);
        total++;
        if (acc_valid !== 1'b1 || acc_out !== 18'd4) begin
            bad++; $display("FAIL flush_sum got valid=%0b out=%0d want valid=1 out=4", acc_valid, acc_out);
        end

        do_reset();
        send(9, 1'b1);
        send(9, 1'b1);
        total++;
        if (beat_cnt !== 2'd2) begin bad++; $display("FAIL midrst_beat got=%0d want=2", beat_cnt); end
        drive(1'b1, 1'b1, 9, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 4; i++) send(2, 1'b1);
        total++;
        if (acc_valid !== 1'b1 || acc_out !== 18'd8) begin
            bad++; $display("FAIL midrst_sum got valid=%0b out=%0d want valid=1 out=8", acc_valid, acc_out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  $urandom,
                  ($urandom_range(0, 19) == 0),
                  1'($urandom));
            step();
            total++;
            if (acc_valid !== m_valid || acc_out !== m_out || overrun !== m_over ||
                int'(beat_cnt) != frame_q.size()) begin
                bad++;
                $display("FAIL random cyc=%0d got v=%0b out=%0d ovr=%0b beat=%0d want v=%0b out=%0d ovr=%0b beat=%0d",
                         i, acc_valid, acc_out, overrun, beat_cnt, m_valid, m_out, m_over, frame_q.size());
            end
        end
    endtask

    initial begin
        m_valid = 1'b0;
        m_out   = '0;
        m_over  = 1'b0;
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        test_reset();
        test_basic_frame(1'b0);
        test_basic_frame(1'b1);
        test_max_values();
        test_backpressure();
        test_back_to_back();
        test_flush_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
